// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer_if
// Brief    : Pin-side input and clean-level outputs of the button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
  parameter int BOUNCE_W = 8
);
  logic                button_raw;
  logic                button_stable;
  logic                press_pulse;
  logic                release_pulse;
  logic [BOUNCE_W-1:0] bounce_count;

  // master: the debouncer itself; slave: the pin driver / downstream consumer
  modport master (
    input  button_raw,
    output button_stable,
    output press_pulse,
    output release_pulse,
    output bounce_count
  );

  modport slave (
    output button_raw,
    input  button_stable,
    input  press_pulse,
    input  release_pulse,
    input  bounce_count
  );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronizes and debounces a push-button pin, emits press/release
//            strobes and a saturating count of aborted transitions.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int SYNC_STAGES       = 2,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int BOUNCE_W          = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  button_debouncer_if.master  btn
);

  localparam int                 c_CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic               c_ACTIVE_LOW = (BUTTON_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic [BOUNCE_W-1:0]    r_bounce;
  logic [BOUNCE_W-1:0]    w_bounce_nxt;
  logic [BOUNCE_W-1:0]    w_bounce_sat;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   r_press;
  logic                   w_press_nxt;
  logic                   r_release;
  logic                   w_release_nxt;

  // Chain resets to the released pin level so reset release never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{c_ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn.button_raw};
    end
  end

  assign w_btn_s      = r_sync[SYNC_STAGES-1] ^ c_ACTIVE_LOW;
  assign w_bounce_sat = (r_bounce == {BOUNCE_W{1'b1}}) ? r_bounce : r_bounce + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RELEASED;
      r_cnt     <= '0;
      r_bounce  <= '0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bounce  <= w_bounce_nxt;
      r_stable  <= w_stable_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bounce_nxt  = r_bounce;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_RELEASED: begin
        if (w_btn_s) begin
          w_state_nxt = S_PRESS_CHK;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      S_PRESS_CHK: begin
        // A reversal takes priority over completing the check
        if (!w_btn_s) begin
          w_state_nxt  = S_RELEASED;
          w_bounce_nxt = w_bounce_sat;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = S_RELEASE_CHK;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      S_RELEASE_CHK: begin
        if (w_btn_s) begin
          w_state_nxt  = S_PRESSED;
          w_bounce_nxt = w_bounce_sat;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = S_RELEASED;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
      end
    endcase
    w_stable_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_CHK);
  end

  assign btn.button_stable = r_stable;
  assign btn.press_pulse   = r_press;
  assign btn.release_pulse = r_release;
  assign btn.bounce_count  = r_bounce;

endmodule
`default_nettype wire
